// File: rtl/nibble_serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, data LSB first,
// optional even parity, stop bit; each bit held CLKS_PER_BIT clocks.
module nibble_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load,
  input  logic [DATA_W-1:0] da,
  output logic              ready,
  output logic              busy,
  output logic              txd,
  output logic              done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_bit;
  logic              bit_end;
  logic [DATA_W-1:0] shift_next;

  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign shift_next = shift_reg >> 1;

  // txd is loaded with the value of the state being entered, so the line
  // changes on the same edge as the state and never glitches.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      txd        <= 1'b1;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (load) begin
            shift_reg  <= da;
            parity_bit <= ^da;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            state      <= START;
            txd        <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            txd   <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= shift_next;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                txd   <= parity_bit;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              txd     <= shift_next[0];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            txd   <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            txd   <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Bench for nibble_serial_tx: default instance (a) and a no-parity,
// one-clock-per-bit instance (b), checked against a per-cycle frame model.
module tb_nibble_serial_tx;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       a_load, b_load;
  logic [3:0] a_da, b_da;
  logic       a_ready, a_busy, a_txd, a_done;
  logic       b_ready, b_busy, b_txd, b_done;

  int tests_run = 0;
  int tests_failed = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  nibble_serial_tx dut_a (
    .clk(clk), .clr_n(clr_n), .load(a_load), .da(a_da),
    .ready(a_ready), .busy(a_busy), .txd(a_txd), .done(a_done)
  );

  nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
    .clk(clk), .clr_n(clr_n), .load(b_load), .da(b_da),
    .ready(b_ready), .busy(b_busy), .txd(b_txd), .done(b_done)
  );

  // Expected txd, one entry per clock, from the frame-format rules.
  function automatic void build_frame(input logic [3:0] data, input int cpb, input bit par_en);
    bit bits[$];
    exp_q = {};
    bits.push_back(1'b0);
    for (int k = 0; k < 4; k++) bits.push_back(data[k]);
    if (par_en) bits.push_back(^data);
    bits.push_back(1'b1);
    foreach (bits[k]) for (int c = 0; c < cpb; c++) exp_q.push_back(bits[k]);
  endfunction

  // {txd, busy, ready, done} of the selected instance
  function automatic logic [3:0] observe(input bit sel);
    return sel ? {b_txd, b_busy, b_ready, b_done} : {a_txd, a_busy, a_ready, a_done};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] obs;
    clr_n = 1'b1; a_load = 0; b_load = 0; a_da = 0; b_da = 0;
    #2 clr_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      obs = observe(s[0]);
      tests_run++;
      if (obs !== 4'b1010) begin
        tests_failed++;
        $display("FAIL reset_async dut%0d: {txd,busy,ready,done}=%b required 1010", s, obs);
      end
    end
    tick();
    obs = observe(1'b0);
    tests_run++;
    if (obs !== 4'b1010) begin
      tests_failed++;
      $display("FAIL reset_held: {txd,busy,ready,done}=%b required 1010", obs);
    end
    #3 clr_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [3:0] obs;
    build_frame(4'b1011, 4, 1'b1);
    a_da = 4'b1011; a_load = 1'b1;
    tick();
    a_load = 1'b0;
    foreach (exp_q[i]) begin
      obs = observe(1'b0);
      tests_run++;
      if (obs !== {exp_q[i], 3'b100}) begin
        tests_failed++;
        $display("FAIL basic cycle %0d: {txd,busy,ready,done}=%b required %b100", i, obs, exp_q[i]);
      end
      tick();
    end
    obs = observe(1'b0);
    tests_run++;
    if (obs !== 4'b1011) begin
      tests_failed++;
      $display("FAIL basic_done: {txd,busy,ready,done}=%b required 1011", obs);
    end
    tick();
    obs = observe(1'b0);
    tests_run++;
    if (obs !== 4'b1010) begin
      tests_failed++;
      $display("FAIL basic_after_done: {txd,busy,ready,done}=%b required 1010", obs);
    end
  endtask

  task automatic test_no_parity;
    logic [3:0] obs;
    build_frame(4'b0110, 1, 1'b0);
    b_da = 4'b0110; b_load = 1'b1;
    tick();
    b_load = 1'b0;
    foreach (exp_q[i]) begin
      obs = observe(1'b1);
      tests_run++;
      if (obs !== {exp_q[i], 3'b100}) begin
        tests_failed++;
        $display("FAIL no_parity cycle %0d: {txd,busy,ready,done}=%b required %b100", i, obs, exp_q[i]);
      end
      tick();
    end
    obs = observe(1'b1);
    tests_run++;
    if (obs !== 4'b1011) begin
      tests_failed++;
      $display("FAIL no_parity_done: {txd,busy,ready,done}=%b required 1011", obs);
    end
    tick();
  endtask

  task automatic test_ignore_load;
    logic [3:0] obs;
    build_frame(4'b1011, 4, 1'b1);
    a_da = 4'b1011; a_load = 1'b1;
    tick();
    a_load = 1'b0;
    foreach (exp_q[i]) begin
      obs = observe(1'b0);
      tests_run++;
      if (obs !== {exp_q[i], 3'b100}) begin
        tests_failed++;
        $display("FAIL ignore_load cycle %0d: {txd,busy,ready,done}=%b required %b100", i, obs, exp_q[i]);
      end
      if (i == 5) begin a_load = 1'b1; a_da = 4'b0000; end
      if (i == 6) a_load = 1'b0;
      tick();
    end
    obs = observe(1'b0);
    tests_run++;
    if (obs !== 4'b1011) begin
      tests_failed++;
      $display("FAIL ignore_load_done: {txd,busy,ready,done}=%b required 1011", obs);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      obs = observe(1'b0);
      tests_run++;
      if (obs !== 4'b1010) begin
        tests_failed++;
        $display("FAIL ignore_load_idle %0d: {txd,busy,ready,done}=%b required 1010", c, obs);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] obs;
    build_frame(4'b1111, 4, 1'b1);
    a_da = 4'b1111; a_load = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      foreach (exp_q[i]) begin
        obs = observe(1'b0);
        tests_run++;
        if (obs !== {exp_q[i], 3'b100}) begin
          tests_failed++;
          $display("FAIL back_to_back frame %0d cycle %0d: {txd,busy,ready,done}=%b required %b100", f, i, obs, exp_q[i]);
        end
        if (f == 2 && i == 0) a_load = 1'b0;
        tick();
      end
      obs = observe(1'b0);
      tests_run++;
      if (obs !== 4'b1011) begin
        tests_failed++;
        $display("FAIL back_to_back_gap frame %0d: {txd,busy,ready,done}=%b required 1011", f, obs);
      end
      tick();
    end
    obs = observe(1'b0);
    tests_run++;
    if (obs !== 4'b1010) begin
      tests_failed++;
      $display("FAIL back_to_back_end: {txd,busy,ready,done}=%b required 1010", obs);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] obs;
    logic [3:0] data;
    data = 4'($urandom_range(0, 15));
    build_frame(data, 4, 1'b1);
    a_da = data; a_load = 1'b1;
    tick();
    a_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      obs = observe(1'b0);
      tests_run++;
      if (obs !== {exp_q[i], 3'b100}) begin
        tests_failed++;
        $display("FAIL abort_pre cycle %0d: {txd,busy,ready,done}=%b required %b100", i, obs, exp_q[i]);
      end
      tick();
    end
    #2 clr_n = 1'b0;
    #1;
    obs = observe(1'b0);
    tests_run++;
    if (obs !== 4'b1010) begin
      tests_failed++;
      $display("FAIL abort_async: {txd,busy,ready,done}=%b required 1010", obs);
    end
    #1 clr_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      obs = observe(1'b0);
      tests_run++;
      if (obs !== 4'b1010) begin
        tests_failed++;
        $display("FAIL abort_residual %0d: {txd,busy,ready,done}=%b required 1010", c, obs);
      end
    end
    data = 4'($urandom_range(0, 15));
    build_frame(data, 4, 1'b1);
    a_da = data; a_load = 1'b1;
    tick();
    a_load = 1'b0;
    foreach (exp_q[i]) begin
      obs = observe(1'b0);
      tests_run++;
      if (obs !== {exp_q[i], 3'b100}) begin
        tests_failed++;
        $display("FAIL abort_recover da=%b cycle %0d: {txd,busy,ready,done}=%b required %b100", data, i, obs, exp_q[i]);
      end
      tick();
    end
    obs = observe(1'b0);
    tests_run++;
    if (obs !== 4'b1011) begin
      tests_failed++;
      $display("FAIL abort_recover_done: {txd,busy,ready,done}=%b required 1011", obs);
    end
  endtask

  task automatic test_random;
    logic [3:0] obs;
    logic [3:0] data;
    bit sel;
    int gap;
    for (int n = 0; n < 16; n++) begin
      sel  = 1'($urandom_range(0, 1));
      data = 4'($urandom_range(0, 15));
      gap  = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      if (sel) build_frame(data, 1, 1'b0);
      else     build_frame(data, 4, 1'b1);
      if (sel) begin b_da = data; b_load = 1'b1; end
      else     begin a_da = data; a_load = 1'b1; end
      tick();
      a_load = 1'b0; b_load = 1'b0;
      foreach (exp_q[i]) begin
        obs = observe(sel);
        tests_run++;
        if (obs !== {exp_q[i], 3'b100}) begin
          tests_failed++;
          $display("FAIL random %0d dut%0d da=%b cycle %0d: {txd,busy,ready,done}=%b required %b100",
                   n, sel, data, i, obs, exp_q[i]);
        end
        tick();
      end
      obs = observe(sel);
      tests_run++;
      if (obs !== 4'b1011) begin
        tests_failed++;
        $display("FAIL random_done %0d dut%0d: {txd,busy,ready,done}=%b required 1011", n, sel, obs);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_parity();
    test_ignore_load();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
